i2c_master_ctrl: RTL and testbench
==================================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 250, meaning clk cycles per SCL quarter-period (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_addr  input  7  target slave address.
REQ-007 SHALL have port cmd_rw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port cmd_len  input  8  data byte count; 0 = address-only probe.
REQ-009 SHALL have port tx_data  input  8  write byte, sampled in the clk cycle where tx_req = 1.
REQ-010 SHALL have port tx_req  output  1  one-clk pulse requesting the next write byte.
REQ-011 SHALL have port rx_data  output  8  last received byte, held until the next rx_valid.
REQ-012 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-013 SHALL have port done  output  1  one-clk pulse at the end of the command.
REQ-014 SHALL have port nack  output  1  set when the slave NACKs; cleared on the next command accept.
REQ-015 SHALL have port scl  output  1  push-pull SCL; no clock stretching.
REQ-016 SHALL have port sda  inout  1  open-drain: drives 0 or z, never 1.

Function
REQ-017 SHALL latch addr, rw and len on accept; cmd_valid in any other state SHALL be ignored.
REQ-018 SHALL advance the bus on a tick every DIV clks; the tick counter SHALL reload to 0 on accept and wrap at DIV-1.
REQ-019 SHALL implement FSM states IDLE, START, ADDR, ADDR_ACK, TX, TX_ACK, RX, RX_ACK, STOP.
REQ-020 SHALL split each bit in ADDR/TX/RX/ACK states into 4 quarters: q0 SCL low and SDA updated; q1 SCL high; q2 SDA sampled; q3 SCL high, falling at the end.
REQ-021 SHALL make START 2 quarters (q0 SDA low with SCL high; q1 SCL high then low) and STOP 3 quarters (SDA low SCL low; SCL high; SDA released).
REQ-022 SHALL send ADDR MSB-first as {addr, rw} (8 bits), then ADDR_ACK releases SDA and samples the ACK.
REQ-023 On address NACK SHALL set nack and go to STOP, regardless of len.
REQ-024 On address ACK with len=0 SHALL go to STOP; otherwise to TX (rw=0) or RX (rw=1).
REQ-025 SHALL pulse tx_req in the clk where TX is entered and load tx_data into the shift register in that same cycle.
REQ-026 In TX_ACK, a slave NACK SHALL set nack and go to STOP; an ACK SHALL go to TX if bytes remain, else STOP.
REQ-027 RX SHALL shift SDA in MSB-first at q2; rx_data/rx_valid SHALL update at RX exit.
REQ-028 In RX_ACK the master SHALL drive ACK (0) if bytes remain and release SDA (NACK) on the last byte.
REQ-029 SHALL use an 8-bit remaining-byte counter and a 3-bit bit counter, with no wrap past 0.
REQ-030 SHALL pulse done on STOP→IDLE; cmd→done duration SHALL be (5+36*(1+N))*DIV clks ±1, where N=len (success) or 0 (address NACK).

Reset
REQ-031 While reset is asserted SHALL hold: state IDLE, scl=1, sda=z, cmd_ready=1, tx_req=0, rx_valid=0, done=0, nack=0, rx_data=0, all counters 0.
REQ-032 Reset mid-transaction SHALL release the bus immediately, without generating a STOP and without pulsing done.

Structure
REQ-033 Package i2c_pkg SHALL hold the FSM state enum, the quarter-phase typedef and the R/W bit encoding constants.
REQ-034 Sub-module i2c_tick_gen (DIV counter emitting a one-clk tick) SHALL be instantiated once.

Verification
REQ-035 DIV=4, write addr 0x50, len 2, tx 0xA5 then 0x3C, against i2c_slave ADRS 0x50 -> 2 tx_req pulses, nack=0, done at 452±1 clks.
REQ-036 Read addr 0x50, len 3, slave returns 0x11/0x22/0x33 -> 3 rx_valid pulses with those values; master ACK,ACK,NACK; STOP follows.
REQ-037 Write addr 0x51 (no slave) -> nack=1, no tx_req pulse, STOP issued, done at 164±1 clks.
REQ-038 len=0 probe of 0x50 -> nack=0, no tx_req/rx_valid pulses, done at 164±1 clks.
REQ-039 Assert reset during the 2nd data byte -> scl=1, sda=z, cmd_ready=1 in the same cycle, no done pulse; next command completes normally.
REQ-040 Assert cmd_valid while busy -> command ignored; the in-flight transaction and its byte counts are unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg
// Shared definitions for the I2C master controller:
//   state_t   - controller FSM states
//   quarter_t - quarter-phase index within one SCL bit period
//   RW_*      - value of the R/W bit that follows the 7-bit address
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Bit counter start value: bytes go out / come in MSB first.
    localparam logic [2:0] BIT_MSB = 3'd7;

endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen
// Divides clk down to one tick per SCL quarter-period.
// Ports:
//   clk     - clock
//   reset   - asynchronous active-high reset
//   i_clear - restart the count from 0 (a new command is being accepted)
//   o_tick  - one-clk pulse on the last cycle of each DIV-cycle period
module i2c_tick_gen #(
    parameter int DIV = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Suppressed while clearing so the first quarter after accept is full length.
    assign o_tick = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
// Single-master I2C controller: START, 7-bit address + R/W, len data bytes
// (written from tx_data or read into rx_data), STOP. Every bus bit is split
// into four DIV-clk quarters.
// Ports:
//   clk, reset                   - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          - command handshake (ready only when idle)
//   cmd_addr, cmd_rw, cmd_len    - target address, 1=read, byte count (0=probe)
//   tx_data, tx_req              - next write byte, sampled while tx_req=1
//   rx_data, rx_valid            - last received byte and its update strobe
//   done, nack                   - end-of-command pulse, slave-NACK flag
//   scl, sda                     - push-pull SCL, open-drain SDA
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int DIV = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_len,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       done,
    output logic       nack,
    output logic       scl,
    inout  wire        sda
);

    state_t     r_state;
    quarter_t   r_quarter;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_remaining;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_sample;
    logic       r_cmd_ready;
    logic       r_tx_req;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_done;
    logic       r_nack;
    logic       r_scl;
    logic       r_sda_low;

    logic w_accept;
    logic w_tick;
    logic w_sda_in;
    logic w_tx_bit;
    logic w_scl;
    logic w_sda_low;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_sda_in = sda;

    i2c_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_accept),
        .o_tick  (w_tick)
    );

    // The write byte is loaded one clk after TX entry; during that clk take
    // its MSB straight from tx_data so SDA never shows a stale bit.
    assign w_tx_bit = r_tx_req ? tx_data[7] : r_shift[7];

    // Bus levels for the current state/quarter; registered below.
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (r_state)
            ST_START: begin
                w_sda_low = 1'b1;
            end
            ST_ADDR, ST_TX: begin
                w_scl     = (r_quarter != Q0);
                w_sda_low = !w_tx_bit;
            end
            ST_ADDR_ACK, ST_TX_ACK, ST_RX: begin
                w_scl = (r_quarter != Q0);
            end
            ST_RX_ACK: begin
                w_scl     = (r_quarter != Q0);
                w_sda_low = (r_remaining != 8'd0);
            end
            ST_STOP: begin
                w_scl     = (r_quarter != Q0);
                w_sda_low = (r_quarter != Q2);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_quarter   <= Q0;
            r_bit_cnt   <= '0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_rw        <= 1'b0;
            r_sample    <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_tx_req    <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_low   <= 1'b0;
        end else begin
            r_tx_req   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_scl      <= w_scl;
            r_sda_low  <= w_sda_low;

            if (r_tx_req) begin
                r_shift <= tx_data;
            end

            if (w_accept) begin
                r_state     <= ST_START;
                r_quarter   <= Q0;
                r_shift     <= {cmd_addr, cmd_rw};
                r_rw        <= cmd_rw;
                r_remaining <= cmd_len;
                r_bit_cnt   <= BIT_MSB;
                r_nack      <= 1'b0;
                r_cmd_ready <= 1'b0;
            end else if (w_tick && r_state != ST_IDLE) begin
                r_quarter <= quarter_t'(r_quarter + 2'd1);
                if (r_quarter == Q2) begin
                    r_sample <= w_sda_in;
                end

                case (r_state)
                    ST_START: begin
                        if (r_quarter == Q1) begin
                            r_state   <= ST_ADDR;
                            r_quarter <= Q0;
                        end
                    end

                    ST_ADDR, ST_TX: begin
                        if (r_quarter == Q3) begin
                            if (r_bit_cnt == 3'd0) begin
                                if (r_state == ST_ADDR) begin
                                    r_state <= ST_ADDR_ACK;
                                end else begin
                                    r_state <= ST_TX_ACK;
                                    if (r_remaining != 8'd0) begin
                                        r_remaining <= r_remaining - 8'd1;
                                    end
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                                r_shift   <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end

                    ST_RX: begin
                        if (r_quarter == Q2) begin
                            r_shift <= {r_shift[6:0], w_sda_in};
                        end
                        if (r_quarter == Q3) begin
                            if (r_bit_cnt == 3'd0) begin
                                r_state    <= ST_RX_ACK;
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                                if (r_remaining != 8'd0) begin
                                    r_remaining <= r_remaining - 8'd1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end
                    end

                    ST_ADDR_ACK, ST_TX_ACK: begin
                        if (r_quarter == Q3) begin
                            // A high SDA at q2 means nobody acknowledged.
                            if (r_sample) begin
                                r_nack  <= 1'b1;
                                r_state <= ST_STOP;
                            end else if (r_remaining == 8'd0) begin
                                r_state <= ST_STOP;
                            end else if (r_state == ST_ADDR_ACK && r_rw == RW_READ) begin
                                r_state   <= ST_RX;
                                r_bit_cnt <= BIT_MSB;
                            end else begin
                                r_state   <= ST_TX;
                                r_bit_cnt <= BIT_MSB;
                                r_tx_req  <= 1'b1;
                            end
                        end
                    end

                    ST_RX_ACK: begin
                        if (r_quarter == Q3) begin
                            if (r_remaining != 8'd0) begin
                                r_state   <= ST_RX;
                                r_bit_cnt <= BIT_MSB;
                            end else begin
                                r_state <= ST_STOP;
                            end
                        end
                    end

                    ST_STOP: begin
                        if (r_quarter == Q2) begin
                            r_state     <= ST_IDLE;
                            r_quarter   <= Q0;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                        end
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_quarter <= Q0;
                    end
                endcase
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign tx_req    = r_tx_req;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign done      = r_done;
    assign nack      = r_nack;
    assign scl       = r_scl;
    assign sda       = r_sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl
// Bench for i2c_master_ctrl (DIV=4) with a behavioural slave at 0x50 on a
// pulled-up SDA line. Expected results come from transaction-level rules:
// byte counts, ACK/NACK outcome and the quarter-count duration formula.
module tb_i2c_master_ctrl;
    import i2c_pkg::*;

    localparam int         DIV      = 4;
    localparam logic [6:0] SLV_ADRS = 7'h50;
    localparam int SL_IDLE = 0, SL_ADDR = 1, SL_WR = 2, SL_RD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_len = '0;
    logic [7:0] tx_data = '0;
    logic       cmd_ready, tx_req, rx_valid, done, nack, scl;
    logic [7:0] rx_data;
    wire        sda_bus;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_len   (cmd_len),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .done      (done),
        .nack      (nack),
        .scl       (scl),
        .sda       (sda_bus)
    );

    // ---------------- behavioural slave ----------------
    logic       sl_drive = 1'b0;
    assign sda_bus = sl_drive ? 1'b0 : 1'bz;
    pullup (sda_bus);

    logic [7:0] rd_q[$];
    logic [7:0] got_wr[$];
    logic       got_ack[$];
    int         sl_nack_at = 255;
    int         start_cnt = 0;
    int         stop_cnt = 0;

    initial begin
        logic       prev_scl, prev_sda, cur_scl, cur_sda, sl_rw, sl_ack_bit;
        logic [7:0] sl_byte, sl_rd_byte;
        int         sl_state, sl_cnt, sl_wr_idx;
        prev_scl = 1'b1; prev_sda = 1'b1; sl_state = SL_IDLE; sl_cnt = 0;
        sl_wr_idx = 0; sl_byte = '0; sl_rd_byte = 8'hFF; sl_rw = 1'b0; sl_ack_bit = 1'b1;
        forever begin
            @(negedge clk);
            cur_scl = scl;
            cur_sda = sda_bus;
            if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
                start_cnt++; sl_state = SL_ADDR; sl_cnt = 0; sl_drive = 1'b0; sl_wr_idx = 0;
            end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
                stop_cnt++; sl_state = SL_IDLE; sl_drive = 1'b0;
            end else if (!prev_scl && cur_scl && sl_state != SL_IDLE) begin
                if (sl_cnt < 8) sl_byte = {sl_byte[6:0], cur_sda};
                else            sl_ack_bit = cur_sda;
                sl_cnt++;
            end else if (prev_scl && !cur_scl && sl_state != SL_IDLE) begin
                if (sl_cnt == 8) begin
                    if (sl_state == SL_ADDR) begin
                        if (sl_byte[7:1] == SLV_ADRS) begin
                            sl_drive = 1'b1; sl_rw = sl_byte[0];
                        end else begin
                            sl_state = SL_IDLE; sl_drive = 1'b0;
                        end
                    end else if (sl_state == SL_WR) begin
                        got_wr.push_back(sl_byte);
                        sl_drive = (sl_wr_idx != sl_nack_at);
                        sl_wr_idx++;
                    end else begin
                        sl_drive = 1'b0;
                    end
                end else if (sl_cnt == 9) begin
                    sl_cnt = 0;
                    if (sl_state == SL_ADDR) begin
                        if (sl_rw == RW_READ) begin
                            sl_state = SL_RD;
                            sl_rd_byte = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
                            sl_drive = !sl_rd_byte[7];
                        end else begin
                            sl_state = SL_WR; sl_drive = 1'b0;
                        end
                    end else if (sl_state == SL_WR) begin
                        sl_drive = 1'b0;
                    end else begin
                        got_ack.push_back(sl_ack_bit);
                        if (!sl_ack_bit) begin
                            sl_rd_byte = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
                            sl_drive = !sl_rd_byte[7];
                        end else begin
                            sl_state = SL_IDLE; sl_drive = 1'b0;
                        end
                    end
                end else if (sl_state == SL_RD && sl_cnt >= 1 && sl_cnt <= 7) begin
                    sl_drive = !sl_rd_byte[3'(7 - sl_cnt)];
                end
            end
            prev_scl = cur_scl;
            prev_sda = cur_sda;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] wr_bytes[$];
    logic [7:0] rd_exp[$];
    int         txn_no = 0;

    task automatic run_txn(input logic [6:0] addr, input logic rw, input logic [7:0] len,
                           input int nack_at, input bit garbage);
        int         nbytes, exp_cycles, exp_tx, exp_rx, cyc, ntx, tx_idx, s0, bound;
        logic       exp_nack;
        bit         seen;
        logic [7:0] rx_got[$];

        // reference: transaction outcome from the protocol rules
        if (addr != SLV_ADRS) begin
            nbytes = 0; exp_nack = 1'b1;
        end else if (rw == RW_WRITE && nack_at < int'(len)) begin
            nbytes = nack_at + 1; exp_nack = 1'b1;
        end else begin
            nbytes = int'(len); exp_nack = 1'b0;
        end
        exp_cycles = (5 + 36 * (1 + nbytes)) * DIV;
        exp_tx = (rw == RW_WRITE) ? nbytes : 0;
        exp_rx = (rw == RW_READ) ? nbytes : 0;

        got_wr.delete(); got_ack.delete(); rd_q = rd_exp;
        sl_nack_at = nack_at; s0 = stop_cnt;

        @(negedge clk);
        check_val("ready_before_cmd", cmd_ready, 1);
        cmd_addr = addr; cmd_rw = rw; cmd_len = len; cmd_valid = 1'b1;
        @(posedge clk);
        seen = 0; cyc = 0; ntx = 0; tx_idx = 0;
        bound = exp_cycles + 50;
        while (cyc < bound) begin
            @(negedge clk);
            cmd_valid = garbage && cyc >= 10 && cyc < 40;
            if (cmd_valid) begin
                cmd_addr = 7'($urandom); cmd_rw = 1'($urandom); cmd_len = 8'($urandom);
            end
            if (cyc == 5) check_val("ready_while_busy", cmd_ready, 0);
            if (tx_req) begin
                ntx++;
                tx_data = (tx_idx < wr_bytes.size()) ? wr_bytes[tx_idx] : 8'h00;
                tx_idx++;
            end else begin
                tx_data = 8'($urandom);
            end
            if (rx_valid) rx_got.push_back(rx_data);
            if (done) begin
                seen = 1;
                break;
            end
            cyc++;
        end
        cmd_valid = 1'b0;
        check_val("done_seen", seen, 1);
        check_val("done_cycles", (cyc >= exp_cycles - 1 && cyc <= exp_cycles + 1) ? exp_cycles : cyc,
                  exp_cycles);
        check_val("nack", nack, exp_nack);
        check_val("tx_req_count", ntx, exp_tx);
        check_val("slave_wr_count", got_wr.size(), exp_tx);
        for (int i = 0; i < exp_tx && i < got_wr.size(); i++)
            check_val("slave_wr_byte", got_wr[i], wr_bytes[i]);
        check_val("rx_count", rx_got.size(), exp_rx);
        for (int i = 0; i < exp_rx && i < rx_got.size(); i++)
            check_val("rx_byte", rx_got[i], rd_exp[i]);
        check_val("master_ack_count", got_ack.size(), exp_rx);
        for (int i = 0; i < exp_rx && i < got_ack.size(); i++)
            check_val("master_ack_bit", got_ack[i], (i == exp_rx - 1) ? 1 : 0);
        @(negedge clk);
        check_val("done_one_pulse", done, 0);
        check_val("stop_seen", stop_cnt - s0, 1);
        check_val("idle_scl", scl, 1);
        check_val("idle_sda", sda_bus, 1);
        check_val("idle_ready", cmd_ready, 1);
        $display("txn %0d addr=0x%02h rw=%0d len=%0d nack_at=%0d busy_cmds=%0d -> nack=%0b tx=%0d rx=%0d cycles=%0d (exp %0d)",
                 txn_no, addr, rw, len, nack_at, garbage, nack, ntx, rx_got.size(), cyc, exp_cycles);
        txn_no++;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_scl"}, scl, 1);
        check_val({tag, "_sda"}, sda_bus, 1);
        check_val({tag, "_ready"}, cmd_ready, 1);
        check_val({tag, "_tx_req"}, tx_req, 0);
        check_val({tag, "_rx_valid"}, rx_valid, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_nack"}, nack, 0);
        check_val({tag, "_rx_data"}, rx_data, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ntx, waited;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // directed: write two bytes to the present slave
        wr_bytes = '{8'hA5, 8'h3C}; rd_exp.delete();
        run_txn(7'h50, RW_WRITE, 8'd2, 255, 0);
        // directed: read three bytes
        wr_bytes.delete(); rd_exp = '{8'h11, 8'h22, 8'h33};
        run_txn(7'h50, RW_READ, 8'd3, 255, 0);
        // directed: absent slave
        wr_bytes = '{8'h01, 8'h02}; rd_exp.delete();
        run_txn(7'h51, RW_WRITE, 8'd2, 255, 0);
        // directed: address-only probe
        wr_bytes.delete();
        run_txn(7'h50, RW_WRITE, 8'd0, 255, 0);
        // directed: commands offered while busy are ignored
        wr_bytes = '{8'h5A, 8'hC3};
        run_txn(7'h50, RW_WRITE, 8'd2, 255, 1);

        // reset during the second data byte
        wr_bytes = '{8'h12, 8'h34, 8'h56}; got_wr.delete(); sl_nack_at = 255;
        @(negedge clk);
        cmd_addr = 7'h50; cmd_rw = RW_WRITE; cmd_len = 8'd3; cmd_valid = 1'b1;
        @(posedge clk);
        ntx = 0; waited = 0;
        while (ntx < 2 && waited < 1000) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (tx_req) begin
                tx_data = wr_bytes[ntx];
                ntx++;
            end
            waited++;
        end
        check_val("abort_reached_byte2", ntx, 2);
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("abort_scl", scl, 1);
        check_val("abort_sda", sda_bus, 1);
        check_val("abort_ready", cmd_ready, 1);
        check_val("abort_done", done, 0);
        repeat (4) @(negedge clk);
        check_reset_state("abort_hold");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        wr_bytes = '{8'hE7};
        run_txn(7'h50, RW_WRITE, 8'd1, 255, 0);

        // randomized traffic
        for (int t = 0; t < 14; t++) begin
            logic [6:0] a;
            logic       rw;
            logic [7:0] len;
            int         na;
            a   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV_ADRS;
            rw  = 1'($urandom_range(0, 1));
            len = 8'($urandom_range(0, 4));
            na  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 255;
            wr_bytes.delete(); rd_exp.delete();
            for (int i = 0; i < int'(len); i++) begin
                wr_bytes.push_back(8'($urandom));
                rd_exp.push_back(8'($urandom));
            end
            run_txn(a, rw, len, na, bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
